// File: rtl/reg_scan_display.sv
// rtl/reg_scan_display.sv - register-file scanner driving a multiplexed two-digit hex display
// Optional build macro: RD_TIMEOUT_EN (abandon a read after 16 WAIT cycles, show 0xEE, raise rd_err)
module reg_scan_display #(
   parameter int ADDR_W      = 3,
   parameter int CLK_DIV     = 50000,
   parameter int DWELL_TICKS = 1000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              show_reg,
   input  logic              step,
   output logic              rd_en,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic              rd_valid,
   input  logic [7:0]        rd_data,
   output logic [6:0]        seg,
   output logic              seg_tg_out,
   output logic              busy,
   output logic              rd_err
);

   localparam int TICK_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int DWELL_W = $clog2(DWELL_TICKS + 1);

   localparam logic [TICK_W-1:0]  TICK_LAST  = TICK_W'(CLK_DIV - 1);
   localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL_TICKS - 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_REQ  = 2'd1;
   localparam logic [1:0] S_WAIT = 2'd2;
   localparam logic [1:0] S_SHOW = 2'd3;

   logic [1:0]         r_state;
   logic [1:0]         w_state_nxt;
   logic [ADDR_W-1:0]  r_addr;
   logic [7:0]         r_disp;
   logic [TICK_W-1:0]  r_tick_cnt;
   logic               r_seg_tg;
   logic [DWELL_W-1:0] r_dwell;

   logic               w_tick;
   logic               w_in_show;
   logic               w_dwell_done;
   logic               w_show_step;
   logic               w_leave_show;
   logic               w_advance;
   logic               w_rd_hit;
   logic               w_timeout;
   logic [3:0]         w_nibble;

   // Refresh tick: one-cycle pulse on the last count of a free-running divider
   assign w_tick = (r_tick_cnt == TICK_LAST);

   // A response only counts while a read is actually outstanding
   assign w_rd_hit = (r_state == S_WAIT) && rd_valid;

   // SHOW exits either on a manual step or when the dwell expires; a step that
   // lands on the expiry cycle still advances the address only once
   assign w_in_show    = (r_state == S_SHOW);
   assign w_dwell_done = w_in_show && w_tick && (r_dwell == DWELL_LAST);
   assign w_show_step  = w_in_show && step;
   assign w_leave_show = w_show_step || w_dwell_done;
   assign w_advance    = w_show_step || (w_dwell_done && show_reg);

`ifdef RD_TIMEOUT_EN
   logic [3:0] r_to_cnt;
   logic       r_err;

   // Count consecutive cycles spent waiting for a response
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         r_to_cnt <= '0;
      else if (r_state == S_WAIT)
         r_to_cnt <= r_to_cnt + 4'd1;
      else
         r_to_cnt <= '0;
   end

   // The 16th silent WAIT cycle gives up on the read
   assign w_timeout = (r_state == S_WAIT) && !rd_valid && (r_to_cnt == 4'd15);

   // Error flag: set by a timeout, cleared by the next good response
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         r_err <= 1'b0;
      else if (w_rd_hit)
         r_err <= 1'b0;
      else if (w_timeout)
         r_err <= 1'b1;
   end

   assign rd_err = r_err;
`else
   assign w_timeout = 1'b0;
   assign rd_err    = 1'b0;
`endif

   // Refresh divider, runs in every state
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         r_tick_cnt <= '0;
      else if (w_tick)
         r_tick_cnt <= '0;
      else
         r_tick_cnt <= r_tick_cnt + TICK_W'(1);
   end

   // Digit select alternates on every refresh tick
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         r_seg_tg <= 1'b0;
      else if (w_tick)
         r_seg_tg <= ~r_seg_tg;
   end

   // Dwell counter: ticks seen in SHOW, restarted whenever SHOW is left
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         r_dwell <= '0;
      else if (!w_in_show || w_leave_show)
         r_dwell <= '0;
      else if (w_tick)
         r_dwell <= r_dwell + DWELL_W'(1);
   end

   // Scan address, wraps naturally at the top of the register file
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         r_addr <= '0;
      else if (w_advance)
         r_addr <= r_addr + ADDR_W'(1);
   end

   // Next-state selection for the read/show sequencer
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  w_state_nxt = S_REQ;
         S_REQ:   w_state_nxt = S_WAIT;
         S_WAIT:  if (w_rd_hit || w_timeout) w_state_nxt = S_SHOW;
         S_SHOW:  if (w_leave_show) w_state_nxt = S_REQ;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Sequencer state register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         r_state <= S_IDLE;
      else
         r_state <= w_state_nxt;
   end

   // Display register keeps the old value until a read completes
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         r_disp <= 8'h00;
      else if (w_rd_hit)
         r_disp <= rd_data;
      else if (w_timeout)
         r_disp <= 8'hEE;
   end

   assign rd_en      = (r_state == S_REQ);
   assign rd_addr    = r_addr;
   assign busy       = (r_state == S_REQ) || (r_state == S_WAIT);
   assign seg_tg_out = r_seg_tg;
   assign w_nibble   = r_seg_tg ? r_disp[7:4] : r_disp[3:0];

   // Active-low hex decode, bit order {g,f,e,d,c,b,a}
   always_comb begin
      seg = 7'b1111111;
      case (w_nibble)
         4'h0: seg = 7'b1000000;
         4'h1: seg = 7'b1111001;
         4'h2: seg = 7'b0100100;
         4'h3: seg = 7'b0110000;
         4'h4: seg = 7'b0011001;
         4'h5: seg = 7'b0010010;
         4'h6: seg = 7'b0000010;
         4'h7: seg = 7'b1111000;
         4'h8: seg = 7'b0000000;
         4'h9: seg = 7'b0010000;
         4'hA: seg = 7'b0001000;
         4'hB: seg = 7'b0000011;
         4'hC: seg = 7'b1000110;
         4'hD: seg = 7'b0100001;
         4'hE: seg = 7'b0000110;
         4'hF: seg = 7'b0001110;
         default: seg = 7'b1111111;
      endcase
   end

endmodule

// File: tb/tb_reg_scan_display.sv
// tb/tb_reg_scan_display.sv - directed/randomised self-checking bench for reg_scan_display
module tb_reg_scan_display;

   localparam int ADDR_W  = 3;
   localparam int CLK_DIV = 4;
   localparam int DWELL   = 2;
   localparam int NADDR   = 1 << ADDR_W;

   logic              clk      = 1'b0;
   logic              rst      = 1'b0;
   logic              show_reg = 1'b0;
   logic              step     = 1'b0;
   logic              rd_valid = 1'b0;
   logic [7:0]        rd_data  = 8'h00;
   logic              rd_en;
   logic [ADDR_W-1:0] rd_addr;
   logic [6:0]        seg;
   logic              seg_tg_out;
   logic              busy;
   logic              rd_err;

   int         checks   = 0;
   int         failures = 0;
   int         edges    = 0;
   int         exp_addr = 0;
   logic [7:0] exp_disp = 8'h00;
   logic       exp_err  = 1'b0;
   int         show_n0  = 0;
   int         e_tmp    = 0;
   logic [6:0] hex_tbl [16];

   reg_scan_display #(
      .ADDR_W      (ADDR_W),
      .CLK_DIV     (CLK_DIV),
      .DWELL_TICKS (DWELL)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .show_reg   (show_reg),
      .step       (step),
      .rd_en      (rd_en),
      .rd_addr    (rd_addr),
      .rd_valid   (rd_valid),
      .rd_data    (rd_data),
      .seg        (seg),
      .seg_tg_out (seg_tg_out),
      .busy       (busy),
      .rd_err     (rd_err)
   );

   always #5 clk = ~clk;

   // rising edges since reset release
   always @(posedge clk or negedge rst) begin
      if (!rst) edges <= 0;
      else      edges <= edges + 1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // model: tick every CLK_DIV cycles toggles the digit, digit picks a nibble of the shown byte
   task automatic check_display();
      logic       tg;
      logic [3:0] nib;
      tg  = ((edges / CLK_DIV) % 2) == 1;
      nib = tg ? exp_disp[7:4] : exp_disp[3:0];
      check("seg_tg_out", 32'(seg_tg_out), 32'(tg));
      check("seg", 32'(seg), 32'(hex_tbl[nib]));
      check("rd_err", 32'(rd_err), 32'(exp_err));
   endtask

   // edge count at which rd_en appears when dwell expires, SHOW entered after n0 edges
   function automatic int next_expiry(input int n0);
      int n = n0;
      int d = 0;
      for (int k = 0; k < 10 * CLK_DIV * DWELL; k++) begin
         if ((n % CLK_DIV) == CLK_DIV - 1) d++;
         if (d == DWELL) return n + 1;
         n++;
      end
      return -1;
   endfunction

   task automatic wait_req(input int exp_edge);
      int waited = 0;
      while (rd_en !== 1'b1 && waited < 200) begin
         check_display();
         @(negedge clk);
         waited++;
      end
      check("rd_en_seen", 32'(rd_en), 32'd1);
      check("rd_addr", 32'(rd_addr), 32'(exp_addr));
      if (exp_edge >= 0) check("rd_en_time", 32'(edges), 32'(exp_edge));
      check("busy_req", 32'(busy), 32'd1);
      check_display();
   endtask

   task automatic expect_read(input logic [7:0] data, input int lat, input int exp_edge, input bit poke_step);
      wait_req(exp_edge);
      if (poke_step) step = 1'b1;
      @(negedge clk);
      check("rd_en_pulse", 32'(rd_en), 32'd0);
      for (int i = 0; i < lat; i++) begin
         check("busy_wait", 32'(busy), 32'd1);
         check("rd_addr_hold", 32'(rd_addr), 32'(exp_addr));
         check_display();
         @(negedge clk);
         step = 1'b0;
      end
      check("busy_wait", 32'(busy), 32'd1);
      rd_valid = 1'b1;
      rd_data  = data;
      @(negedge clk);
      rd_valid = 1'b0;
      step     = 1'b0;
      exp_disp = data;
      exp_err  = 1'b0;
      show_n0  = edges;
      check("busy_show", 32'(busy), 32'd0);
      check("rd_en_show", 32'(rd_en), 32'd0);
      check_display();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      hex_tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                  7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

      // reset state
      repeat (3) @(negedge clk);
      check("rst_rd_en", 32'(rd_en), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_rd_addr", 32'(rd_addr), 32'd0);
      check("rst_seg", 32'(seg), 32'h40);
      check("rst_tg", 32'(seg_tg_out), 32'd0);
      check("rst_err", 32'(rd_err), 32'd0);

      // first read after release: addr 0, answer 0x3C one cycle after rd_en
      rst = 1'b1;
      @(negedge clk);
      expect_read(8'h3C, 0, 1, 1'b0);
      check("seg_C", 32'(seg), 32'(7'b1000110));
      @(negedge clk);
      check("seg_3", 32'(seg), 32'(7'b0110000));

      // show_reg=0: periodic re-read of the same address
      expect_read(8'($urandom), int'($urandom_range(0, 3)), next_expiry(show_n0), 1'b0);

      // auto-scan through the whole file and wrap, ending at the top address
      show_reg = 1'b1;
      for (int i = 0; i < 2 * NADDR - 1; i++) begin
         exp_addr = (exp_addr + 1) % NADDR;
         expect_read(8'($urandom), int'($urandom_range(0, 3)), next_expiry(show_n0), 1'b0);
      end
      check("scan_top", 32'(exp_addr), 32'(NADDR - 1));

      // step on the dwell-expiry cycle at the top address: one increment only
      e_tmp = next_expiry(show_n0);
      while (edges < e_tmp - 1) begin
         check_display();
         @(negedge clk);
      end
      step = 1'b1;
      @(negedge clk);
      step     = 1'b0;
      show_reg = 1'b0;
      exp_addr = 0;
      expect_read(8'($urandom), int'($urandom_range(0, 3)), e_tmp, 1'b0);

      // manual step in SHOW, then steps during REQ/WAIT that must be ignored
      repeat ($urandom_range(0, 2)) @(negedge clk);
      step = 1'b1;
      @(negedge clk);
      step     = 1'b0;
      exp_addr = (exp_addr + 1) % NADDR;
      expect_read(8'($urandom), int'($urandom_range(1, 3)), edges, 1'b1);
      expect_read(8'($urandom), int'($urandom_range(0, 3)), next_expiry(show_n0), 1'b0);

`ifdef RD_TIMEOUT_EN
      // silent register file: give up after 16 WAIT cycles
      wait_req(next_expiry(show_n0));
      @(negedge clk);
      for (int i = 0; i < 16; i++) begin
         check("busy_to", 32'(busy), 32'd1);
         @(negedge clk);
      end
      exp_disp = 8'hEE;
      exp_err  = 1'b1;
      show_n0  = edges;
      check("busy_after_to", 32'(busy), 32'd0);
      check_display();
      expect_read(8'($urandom), int'($urandom_range(0, 3)), next_expiry(show_n0), 1'b0);
`else
      // without the timeout a long silence just keeps the read outstanding
      expect_read(8'($urandom), 40, next_expiry(show_n0), 1'b0);
`endif

      // reset during WAIT, stale response right after release is ignored
      wait_req(next_expiry(show_n0));
      @(negedge clk);
      check("busy_pre_rst", 32'(busy), 32'd1);
      rst = 1'b0;
      #1;
      check("async_busy", 32'(busy), 32'd0);
      check("async_rd_en", 32'(rd_en), 32'd0);
      check("async_addr", 32'(rd_addr), 32'd0);
      exp_addr = 0;
      exp_disp = 8'h00;
      exp_err  = 1'b0;
      check_display();
      @(negedge clk);
      @(negedge clk);
      rst      = 1'b1;
      rd_valid = 1'b1;
      rd_data  = 8'hAA;
      @(negedge clk);
      rd_valid = 1'b0;
      check("stale_ignored", 32'(seg), 32'h40);
      expect_read(8'($urandom), int'($urandom_range(0, 3)), 1, 1'b0);
      expect_read(8'($urandom), int'($urandom_range(0, 3)), next_expiry(show_n0), 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/reg_scan_display.md
REG_SCAN_DISPLAY -- requirements
Module: reg_scan_display

Interface
REQ-001 SHALL have parameter ADDR_W, default 3, register-file address width.
REQ-002 SHALL have parameter CLK_DIV, default 50000, clk cycles per display refresh tick (≥2).
REQ-003 SHALL have parameter DWELL_TICKS, default 1000, refresh ticks each register is shown before the next read (≥1).
REQ-004 SHALL use one clock, clk; reset is asynchronous and active-low, port rst.
REQ-005 clk  in  1  system clock, all state on rising edge.
REQ-006 rst  in  1  asynchronous active-low reset.
REQ-007 show_reg  in  1  level; 1 = auto-scan addresses, 0 = hold current address.
REQ-008 step  in  1  single-cycle debounced pulse; manual advance to next address.
REQ-009 rd_en  out  1  read request to register file, one-cycle pulse.
REQ-010 rd_addr  out  ADDR_W  read address, stable from rd_en until response.
REQ-011 rd_valid  in  1  read response strobe; rd_data valid same cycle.
REQ-012 rd_data  in  8  read data.
REQ-013 seg  out  7  active-low segments {g,f,e,d,c,b,a}.
REQ-014 seg_tg_out  out  1  digit select; 0 = low nibble digit, 1 = high nibble digit.
REQ-015 busy  out  1  high while a read is outstanding (REQ or WAIT).
REQ-016 rd_err  out  1  last read timed out (see Configuration).

Function
REQ-017 SHALL implement FSM IDLE, REQ, WAIT, SHOW; IDLE -> REQ unconditionally on the first clock after reset release.
REQ-018 REQ: rd_en=1 for exactly one cycle with rd_addr=current address; next state WAIT.
REQ-019 WAIT: on rd_valid, latch rd_data into display register, clear rd_err, go SHOW; rd_valid outside WAIT SHALL be ignored.
REQ-020 SHOW: dwell counter counts refresh ticks; at DWELL_TICKS ticks: if show_reg=1 address+1, else address unchanged; go REQ (periodic re-read).
REQ-021 SHOW with step=1 SHALL increment address and go REQ on the next cycle, resetting dwell; step in IDLE/REQ/WAIT SHALL be ignored.
REQ-022 step and dwell expiry in the same cycle SHALL increment address once only.
REQ-023 Address SHALL wrap from 2^ADDR_W-1 to 0.
REQ-024 Refresh tick SHALL be a one-cycle pulse every CLK_DIV clk cycles, free-running in all states; each tick toggles seg_tg_out.
REQ-025 seg SHALL be combinational hex decode of the selected nibble of the display register (0=7'b1000000, 8=7'b0000000, F=7'b0001110, full 0-F table).
REQ-026 Display register SHALL hold its previous value during REQ/WAIT (no blanking mid-read).
REQ-027 busy SHALL be 1 exactly in REQ and WAIT.

Reset
REQ-028 On rst=0, immediately: state IDLE, address 0, rd_en 0, rd_addr 0, display register 0x00, seg_tg_out 0, busy 0, rd_err 0, tick and dwell counters 0.
REQ-029 rst asserted during WAIT SHALL abandon the read; a later rd_valid before the new REQ SHALL be ignored.
REQ-030 seg SHALL read 7'b1000000 ("0") throughout reset.

Configuration
REQ-031 Macro RD_TIMEOUT_EN defined: WAIT SHALL time out after 16 cycles without rd_valid, latch 0xEE into display register, set rd_err=1, go SHOW.
REQ-032 RD_TIMEOUT_EN undefined: WAIT SHALL wait indefinitely; rd_err SHALL be tied 0.

Verification
REQ-033 Reset release, model returns 0x3C one cycle after rd_en -> rd_en pulse at addr 0, busy 2 cycles, display 0x3C, seg alternates "C"(7'b1000110)/"3"(7'b0110000) per tick.
REQ-034 show_reg=1, CLK_DIV=4, DWELL_TICKS=2, ADDR_W=3 -> rd_addr sequence 0,1,...,7,0; a read every 8 clk plus read latency.
REQ-035 show_reg=0, step pulse in SHOW -> address+1, rd_en next cycle; step pulse during WAIT -> no effect.
REQ-036 step coincident with dwell expiry at addr 7 -> next rd_addr 0, not 1.
REQ-037 RD_TIMEOUT_EN defined, no rd_valid -> after 16 WAIT cycles display 0xEE, rd_err=1; next successful read clears rd_err.
REQ-038 rst pulsed low during WAIT, rd_valid with 0xAA right after release -> display stays 0x00, new REQ at addr 0.
